// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - decode types, LEGv8 opcode constants and NZCV bit indices
package ctrl_pkg;

   typedef enum logic [4:0] {
      OP_ILL, OP_ADDI, OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR,
      OP_LSL, OP_LSR, OP_MUL, OP_DIV, OP_B, OP_BL, OP_BR, OP_CBZ, OP_BCOND,
      OP_STUR, OP_LDUR
   } op_e;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_e;

   typedef struct packed {
      op_e        op;
      logic       reg2loc;
      logic       alu_src;
      logic [2:0] alu_op;
      logic       mem_write;
      logic       mem_read;
      logic       mem_to_reg;
      logic       reg_write;
      logic [4:0] rd;
      logic       uncond_br;
      logic       br_taken;
      logic       br_reg;
      logic       save_flags;
      logic [1:0] math_sel;
      logic       left_shift;
      logic       illegal;
   } ctrl_t;

   localparam int NZCV_N = 3;
   localparam int NZCV_Z = 2;
   localparam int NZCV_C = 1;
   localparam int NZCV_V = 0;

   localparam logic [2:0] ALU_AND   = 3'd0;
   localparam logic [2:0] ALU_ORR   = 3'd1;
   localparam logic [2:0] ALU_ADD   = 3'd2;
   localparam logic [2:0] ALU_EOR   = 3'd3;
   localparam logic [2:0] ALU_LSL   = 3'd4;
   localparam logic [2:0] ALU_LSR   = 3'd5;
   localparam logic [2:0] ALU_SUB   = 3'd6;
   localparam logic [2:0] ALU_PASSB = 3'd7;

   localparam logic [1:0] MATH_ALU   = 2'd0;
   localparam logic [1:0] MATH_MUL   = 2'd1;
   localparam logic [1:0] MATH_DIV   = 2'd2;
   localparam logic [1:0] MATH_SHIFT = 2'd3;

   // Short-opcode formats keep their don't-care low bits zero; the masks select significant bits.
   localparam logic [10:0] OPC_ADDI  = 11'b10010001000;
   localparam logic [10:0] OPC_ADD   = 11'b10001011000;
   localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
   localparam logic [10:0] OPC_SUB   = 11'b11001011000;
   localparam logic [10:0] OPC_SUBS  = 11'b11101011000;
   localparam logic [10:0] OPC_AND   = 11'b10001010000;
   localparam logic [10:0] OPC_ORR   = 11'b10101010000;
   localparam logic [10:0] OPC_EOR   = 11'b11001010000;
   localparam logic [10:0] OPC_LSL   = 11'b11010011011;
   localparam logic [10:0] OPC_LSR   = 11'b11010011010;
   localparam logic [10:0] OPC_MUL   = 11'b10011011000;
   localparam logic [10:0] OPC_DIV   = 11'b10011010110;
   localparam logic [10:0] OPC_B     = 11'b00010100000;
   localparam logic [10:0] OPC_BL    = 11'b10010100000;
   localparam logic [10:0] OPC_BR    = 11'b11010110000;
   localparam logic [10:0] OPC_CBZ   = 11'b10110100000;
   localparam logic [10:0] OPC_BCOND = 11'b01010100000;
   localparam logic [10:0] OPC_STUR  = 11'b11111000000;
   localparam logic [10:0] OPC_LDUR  = 11'b11111000010;

   localparam logic [10:0] MASK_R    = 11'b11111111111;
   localparam logic [10:0] MASK_I    = 11'b11111111110;
   localparam logic [10:0] MASK_CB   = 11'b11111111000;
   localparam logic [10:0] MASK_B    = 11'b11111100000;

   function automatic logic opc_hit(input logic [10:0] opc, input logic [10:0] pat,
                                    input logic [10:0] mask);
      return ((opc ^ pat) & mask) == 11'd0;
   endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - ARM condition-code evaluation against an NZCV nibble
module cond_eval
   import ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       taken
);
   logic n, z, c, v;
   logic base;

   assign n = nzcv[NZCV_N];
   assign z = nzcv[NZCV_Z];
   assign c = nzcv[NZCV_C];
   assign v = nzcv[NZCV_V];

   // Odd codes are the complement of the even code below them; 111x is always taken.
   always_comb begin
      base = 1'b1;
      case (cond_e'({cond[3:1], 1'b0}))
         COND_EQ: base = z;
         COND_HS: base = c;
         COND_MI: base = n;
         COND_VS: base = v;
         COND_HI: base = c & ~z;
         COND_GE: base = (n == v);
         COND_GT: base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      taken = (cond[3:1] == 3'b111) ? 1'b1 : (base ^ cond[0]);
   end

endmodule

// File: rtl/decode_issue_ctrl.sv
// rtl/decode_issue_ctrl.sv - LEGv8 decode/issue stage with MUL/DIV issue blocking
// DIV decode is present only when DECODE_DIV_EN is defined.
module decode_issue_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned MULT_LAT = 4,
   parameter int unsigned DIV_LAT  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic        rs_zero,
   input  logic        flag_wr,
   input  logic [3:0]  flag_in,
   input  logic        flush,
   output ctrl_t       ctrl,
   output logic        ctrl_valid,
   input  logic        ctrl_ready,
   output logic        md_busy
);
   logic [5:0]  md_cnt_q, md_cnt_d;
   logic [3:0]  flag_q, flag_d;
   ctrl_t       ctrl_q, ctrl_d, dec;
   logic        ctrl_valid_q, ctrl_valid_d;
   logic        accept, cond_taken;
   logic [10:0] opc;
   logic        unused_instr_bits;

   assign opc               = instr[31:21];
   assign unused_instr_bits = ^instr[20:5];
   assign flag_d            = flag_wr ? flag_in : flag_q;

   // B.cond sees the same-cycle execute flags when they are being written.
   cond_eval u_cond_eval (
      .cond  (instr[3:0]),
      .nzcv  (flag_d),
      .taken (cond_taken)
   );

   assign instr_ready = reset & ~flush & (md_cnt_q == 6'd0) & (~ctrl_valid_q | ctrl_ready);
   assign accept      = instr_valid & instr_ready;

   always_comb begin
      dec    = '0;
      dec.rd = instr[4:0];
      if (opc_hit(opc, OPC_ADDI, MASK_I)) begin
         dec.op = OP_ADDI; dec.alu_src = 1'b1; dec.alu_op = ALU_ADD; dec.reg_write = 1'b1;
      end else if (opc_hit(opc, OPC_ADD, MASK_R)) begin
         dec.op = OP_ADD; dec.alu_op = ALU_ADD; dec.reg_write = 1'b1;
      end else if (opc_hit(opc, OPC_ADDS, MASK_R)) begin
         dec.op = OP_ADDS; dec.alu_op = ALU_ADD; dec.reg_write = 1'b1; dec.save_flags = 1'b1;
      end else if (opc_hit(opc, OPC_SUB, MASK_R)) begin
         dec.op = OP_SUB; dec.alu_op = ALU_SUB; dec.reg_write = 1'b1;
      end else if (opc_hit(opc, OPC_SUBS, MASK_R)) begin
         dec.op = OP_SUBS; dec.alu_op = ALU_SUB; dec.reg_write = 1'b1; dec.save_flags = 1'b1;
      end else if (opc_hit(opc, OPC_AND, MASK_R)) begin
         dec.op = OP_AND; dec.alu_op = ALU_AND; dec.reg_write = 1'b1;
      end else if (opc_hit(opc, OPC_ORR, MASK_R)) begin
         dec.op = OP_ORR; dec.alu_op = ALU_ORR; dec.reg_write = 1'b1;
      end else if (opc_hit(opc, OPC_EOR, MASK_R)) begin
         dec.op = OP_EOR; dec.alu_op = ALU_EOR; dec.reg_write = 1'b1;
      end else if (opc_hit(opc, OPC_LSL, MASK_R)) begin
         dec.op = OP_LSL; dec.alu_src = 1'b1; dec.alu_op = ALU_LSL; dec.reg_write = 1'b1;
         dec.math_sel = MATH_SHIFT; dec.left_shift = 1'b1;
      end else if (opc_hit(opc, OPC_LSR, MASK_R)) begin
         dec.op = OP_LSR; dec.alu_src = 1'b1; dec.alu_op = ALU_LSR; dec.reg_write = 1'b1;
         dec.math_sel = MATH_SHIFT;
      end else if (opc_hit(opc, OPC_MUL, MASK_R)) begin
         dec.op = OP_MUL; dec.reg_write = 1'b1; dec.math_sel = MATH_MUL;
`ifdef DECODE_DIV_EN
      end else if (opc_hit(opc, OPC_DIV, MASK_R)) begin
         dec.op = OP_DIV; dec.reg_write = 1'b1; dec.math_sel = MATH_DIV;
`endif
      end else if (opc_hit(opc, OPC_B, MASK_B)) begin
         dec.op = OP_B; dec.uncond_br = 1'b1; dec.br_taken = 1'b1;
      end else if (opc_hit(opc, OPC_BL, MASK_B)) begin
         dec.op = OP_BL; dec.uncond_br = 1'b1; dec.br_taken = 1'b1; dec.reg_write = 1'b1;
         dec.rd = 5'd30;
      end else if (opc_hit(opc, OPC_BR, MASK_R)) begin
         dec.op = OP_BR; dec.br_reg = 1'b1;
      end else if (opc_hit(opc, OPC_CBZ, MASK_CB)) begin
         dec.op = OP_CBZ; dec.reg2loc = 1'b1; dec.alu_op = ALU_PASSB; dec.br_taken = rs_zero;
      end else if (opc_hit(opc, OPC_BCOND, MASK_CB)) begin
         dec.op = OP_BCOND; dec.br_taken = cond_taken;
      end else if (opc_hit(opc, OPC_STUR, MASK_R)) begin
         dec.op = OP_STUR; dec.reg2loc = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_ADD;
         dec.mem_write = 1'b1;
      end else if (opc_hit(opc, OPC_LDUR, MASK_R)) begin
         dec.op = OP_LDUR; dec.alu_src = 1'b1; dec.alu_op = ALU_ADD; dec.mem_read = 1'b1;
         dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
      end else begin
         dec.op = OP_ILL; dec.illegal = 1'b1;
      end
   end

   // Flush kills only the output slot; the issue-block counter keeps running.
   always_comb begin
      ctrl_d       = ctrl_q;
      ctrl_valid_d = ctrl_valid_q;
      md_cnt_d     = md_cnt_q;
      if (accept) begin
         ctrl_d = dec;
      end
      if (flush) begin
         ctrl_valid_d = 1'b0;
      end else if (accept) begin
         ctrl_valid_d = 1'b1;
      end else if (ctrl_ready) begin
         ctrl_valid_d = 1'b0;
      end
      if (accept && dec.op == OP_MUL) begin
         md_cnt_d = 6'(MULT_LAT);
      end else if (accept && dec.op == OP_DIV) begin
         md_cnt_d = 6'(DIV_LAT);
      end else if (md_cnt_q != 6'd0) begin
         md_cnt_d = md_cnt_q - 6'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_q       <= '0;
         ctrl_valid_q <= 1'b0;
         md_cnt_q     <= 6'd0;
         flag_q       <= 4'd0;
      end else begin
         ctrl_q       <= ctrl_d;
         ctrl_valid_q <= ctrl_valid_d;
         md_cnt_q     <= md_cnt_d;
         flag_q       <= flag_d;
      end
   end

   assign ctrl       = ctrl_q;
   assign ctrl_valid = ctrl_valid_q;
   assign md_busy    = (md_cnt_q != 6'd0);

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb/tb_decode_issue_ctrl.sv - randomized self-checking bench for decode_issue_ctrl
module tb_decode_issue_ctrl;
   import ctrl_pkg::*;

   localparam int MULT_LAT = 4;
   localparam int DIV_LAT  = 16;
`ifdef DECODE_DIV_EN
   localparam logic [10:0] MD_OPC = 11'b10011010110;
   localparam int          MD_LAT = DIV_LAT;
`else
   localparam logic [10:0] MD_OPC = 11'b10011011000;
   localparam int          MD_LAT = MULT_LAT;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic        rs_zero = 1'b0;
   logic        flag_wr = 1'b0;
   logic [3:0]  flag_in = '0;
   logic        flush = 1'b0;
   ctrl_t       ctrl;
   logic        ctrl_valid;
   logic        ctrl_ready = 1'b1;
   logic        md_busy;

   int checks = 0;
   int failures = 0;

   int         m_cnt = 0;
   bit         m_valid = 0;
   logic [3:0] m_flags = '0;
   ctrl_t      m_ctrl = '0;

   always #5 clk = ~clk;

   decode_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .rs_zero(rs_zero), .flag_wr(flag_wr), .flag_in(flag_in),
      .flush(flush), .ctrl(ctrl), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
      .md_busy(md_busy)
   );

   function automatic logic cond_ok(logic [3:0] cd, logic [3:0] f);
      logic n = f[3], z = f[2], c = f[1], v = f[0];
      case (cd)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c && !z;
         4'd9:  return !c || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   function automatic ctrl_t ref_decode(logic [31:0] w, logic rz, logic [3:0] f);
      ctrl_t c = '0;
      logic [10:0] o = w[31:21];
      c.rd = w[4:0];
      casez (o)
         11'b1001000100?: begin c.op = OP_ADDI; c.alu_src = 1; c.alu_op = 3'd2; c.reg_write = 1; end
         11'b10001011000: begin c.op = OP_ADD;  c.alu_op = 3'd2; c.reg_write = 1; end
         11'b10101011000: begin c.op = OP_ADDS; c.alu_op = 3'd2; c.reg_write = 1; c.save_flags = 1; end
         11'b11001011000: begin c.op = OP_SUB;  c.alu_op = 3'd6; c.reg_write = 1; end
         11'b11101011000: begin c.op = OP_SUBS; c.alu_op = 3'd6; c.reg_write = 1; c.save_flags = 1; end
         11'b10001010000: begin c.op = OP_AND;  c.alu_op = 3'd0; c.reg_write = 1; end
         11'b10101010000: begin c.op = OP_ORR;  c.alu_op = 3'd1; c.reg_write = 1; end
         11'b11001010000: begin c.op = OP_EOR;  c.alu_op = 3'd3; c.reg_write = 1; end
         11'b11010011011: begin c.op = OP_LSL; c.alu_src = 1; c.alu_op = 3'd4; c.reg_write = 1;
                                c.math_sel = 2'd3; c.left_shift = 1; end
         11'b11010011010: begin c.op = OP_LSR; c.alu_src = 1; c.alu_op = 3'd5; c.reg_write = 1;
                                c.math_sel = 2'd3; end
         11'b10011011000: begin c.op = OP_MUL; c.reg_write = 1; c.math_sel = 2'd1; end
`ifdef DECODE_DIV_EN
         11'b10011010110: begin c.op = OP_DIV; c.reg_write = 1; c.math_sel = 2'd2; end
`endif
         11'b000101?????: begin c.op = OP_B; c.uncond_br = 1; c.br_taken = 1; end
         11'b100101?????: begin c.op = OP_BL; c.uncond_br = 1; c.br_taken = 1; c.reg_write = 1;
                                c.rd = 5'd30; end
         11'b11010110000: begin c.op = OP_BR; c.br_reg = 1; end
         11'b10110100???: begin c.op = OP_CBZ; c.reg2loc = 1; c.alu_op = 3'd7; c.br_taken = rz; end
         11'b01010100???: begin c.op = OP_BCOND; c.br_taken = cond_ok(w[3:0], f); end
         11'b11111000000: begin c.op = OP_STUR; c.reg2loc = 1; c.alu_src = 1; c.alu_op = 3'd2;
                                c.mem_write = 1; end
         11'b11111000010: begin c.op = OP_LDUR; c.alu_src = 1; c.alu_op = 3'd2; c.mem_read = 1;
                                c.mem_to_reg = 1; c.reg_write = 1; end
         default:         begin c.op = OP_ILL; c.illegal = 1; end
      endcase
      return c;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [10:0] pats [19] = '{11'b10010001000, 11'b10001011000, 11'b10101011000,
         11'b11001011000, 11'b11101011000, 11'b10001010000, 11'b10101010000, 11'b11001010000,
         11'b11010011011, 11'b11010011010, 11'b10011011000, 11'b10011010110, 11'b00010100000,
         11'b10010100000, 11'b11010110000, 11'b10110100000, 11'b01010100000, 11'b11111000000,
         11'b11111000010};
      int dc [19] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 3, 3, 0, 0};
      int k = int'($urandom_range(0, 19));
      logic [10:0] o;
      if (k == 19) o = 11'($urandom);
      else o = pats[k] | (11'($urandom) & 11'((1 << dc[k]) - 1));
      return {o, 21'($urandom)};
   endfunction

   function automatic bit m_ready();
      return reset && !flush && m_cnt == 0 && (!m_valid || ctrl_ready);
   endfunction

   task automatic tick();
      bit acc;
      logic [3:0] nz;
      acc = instr_valid && m_ready();
      nz = flag_wr ? flag_in : m_flags;
      if (!reset) begin
         m_cnt = 0; m_valid = 0; m_flags = '0; m_ctrl = '0;
      end else begin
         if (acc) m_ctrl = ref_decode(instr, rs_zero, nz);
         if (flush) m_valid = 0;
         else if (acc) m_valid = 1;
         else if (ctrl_ready) m_valid = 0;
         if (acc && m_ctrl.op == OP_MUL) m_cnt = MULT_LAT;
         else if (acc && m_ctrl.op == OP_DIV) m_cnt = DIV_LAT;
         else if (m_cnt > 0) m_cnt--;
         m_flags = nz;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 0; instr_valid = 1; instr = {11'b10001011000, 21'h1234};
      tick(); tick();
      checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", instr_ready); end
      checks++; if (ctrl_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ctrl_valid); end
      checks++; if (ctrl !== ctrl_t'(0)) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", ctrl); end
      checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", md_busy); end
      instr_valid = 0; reset = 1;
      tick();
   endtask

   task automatic test_addi();
      instr = {10'b1001000100, 12'd77, 5'd9, 5'd5}; instr_valid = 1; ctrl_ready = 1; #1;
      checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL addi_ready got=%0b exp=1", instr_ready); end
      tick(); instr_valid = 0;
      checks++; if (ctrl_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0b exp=1", ctrl_valid); end
      checks++; if ({ctrl.reg_write, ctrl.alu_src, ctrl.alu_op, ctrl.rd} !== {1'b1, 1'b1, 3'd2, 5'd5}) begin
         failures++; $display("FAIL addi_fields got=%b exp=%b", {ctrl.reg_write, ctrl.alu_src, ctrl.alu_op, ctrl.rd}, {1'b1, 1'b1, 3'd2, 5'd5}); end
      checks++; if (ctrl !== m_ctrl) begin failures++; $display("FAIL addi_ctrl got=%h exp=%h", ctrl, m_ctrl); end
      tick();
   endtask

   task automatic test_mul_block();
      int blocked = 0, busy = 0;
      bit got = 0;
      instr = {11'b10011011000, 21'h0_0C23}; instr_valid = 1; ctrl_ready = 1; #1;
      checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL mul_ready got=%0b exp=1", instr_ready); end
      tick();
      instr = {11'b10001011000, 21'h0_0047};
      for (int i = 0; i < 40 && !got; i++) begin
         #1;
         if (md_busy) busy++;
         if (instr_ready) got = 1; else blocked++;
         tick();
      end
      instr_valid = 0;
      checks++; if (got !== 1'b1 || blocked != MULT_LAT) begin failures++; $display("FAIL mul_blocked got=%0d exp=%0d", blocked, MULT_LAT); end
      checks++; if (busy != MULT_LAT) begin failures++; $display("FAIL mul_busy got=%0d exp=%0d", busy, MULT_LAT); end
      checks++; if (ctrl.op !== OP_ADD || ctrl_valid !== 1'b1) begin failures++; $display("FAIL mul_next_op got=%0d exp=%0d", ctrl.op, OP_ADD); end
      tick();
   endtask

   task automatic test_flag_bypass();
      ctrl_ready = 1; instr_valid = 0; flag_wr = 1; flag_in = 4'b0000; tick();
      instr = {8'b01010100, 19'd3, 1'b0, 4'h0}; flag_in = 4'b0100; instr_valid = 1; #1;
      tick(); flag_wr = 0; instr_valid = 0;
      checks++; if (ctrl.br_taken !== 1'b1) begin failures++; $display("FAIL beq_bypass got=%0b exp=1", ctrl.br_taken); end
      flag_wr = 1; flag_in = 4'b0000; tick();
      instr = {8'b01010100, 19'd3, 1'b0, 4'h1}; flag_in = 4'b0100; instr_valid = 1; #1;
      tick(); flag_wr = 0; instr_valid = 0;
      checks++; if (ctrl.br_taken !== 1'b0) begin failures++; $display("FAIL bne_bypass got=%0b exp=0", ctrl.br_taken); end
      instr = {8'b01010100, 19'd9, 1'b0, 4'h0}; instr_valid = 1; #1;
      tick(); instr_valid = 0;
      checks++; if (ctrl.br_taken !== 1'b1) begin failures++; $display("FAIL beq_flagreg got=%0b exp=1", ctrl.br_taken); end
      tick();
   endtask

   task automatic test_back_to_back();
      ctrl_ready = 1; instr = {11'b10001011000, 16'h0041, 5'd7}; instr_valid = 1; #1;
      tick();
      ctrl_ready = 0; instr = {11'b11001011000, 16'h0062, 5'd8};
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%0b exp=0", i, instr_ready); end
         tick();
         checks++; if (ctrl.op !== OP_ADD || ctrl.rd !== 5'd7 || ctrl_valid !== 1'b1) begin
            failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, ctrl, m_ctrl); end
      end
      ctrl_ready = 1; #1;
      checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b exp=1", instr_ready); end
      tick(); instr_valid = 0;
      checks++; if (ctrl.op !== OP_SUB || ctrl.rd !== 5'd8 || ctrl_valid !== 1'b1) begin
         failures++; $display("FAIL bp_next got=%h exp=%h", ctrl, m_ctrl); end
      tick();
   endtask

   task automatic test_flush();
      int busy = 0;
      ctrl_ready = 1; flush = 0; instr = {MD_OPC, 21'h0_0823}; instr_valid = 1; #1;
      tick();
      instr = {11'b10001011000, 21'h0_0041}; ctrl_ready = 0; flush = 1; #1;
      checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", instr_ready); end
      tick(); flush = 0; instr_valid = 0;
      checks++; if (ctrl_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", ctrl_valid); end
      for (int i = 0; i < 80 && md_busy; i++) begin busy++; tick(); end
      checks++; if (busy != MD_LAT - 1) begin failures++; $display("FAIL flush_countdown got=%0d exp=%0d", busy, MD_LAT - 1); end
      ctrl_ready = 1; flush = 1; instr_valid = 1; #1;
      checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL flush_override got=%0b exp=0", instr_ready); end
      tick(); flush = 0; instr_valid = 0;
      checks++; if (ctrl_valid !== 1'b0) begin failures++; $display("FAIL flush_noaccept got=%0b exp=0", ctrl_valid); end
`ifndef DECODE_DIV_EN
      instr = {11'b10011010110, 21'h0_0823}; instr_valid = 1; #1;
      tick(); instr_valid = 0;
      checks++; if (ctrl.illegal !== 1'b1 || ctrl.reg_write !== 1'b0 || ctrl_valid !== 1'b1) begin
         failures++; $display("FAIL div_illegal got=%h exp=%h", ctrl, m_ctrl); end
      checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL div_busy got=%0b exp=0", md_busy); end
      tick();
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         instr = rand_instr(); instr_valid = ($urandom_range(0, 3) != 0);
         ctrl_ready = ($urandom_range(0, 3) != 0); flag_wr = ($urandom_range(0, 2) == 0);
         flag_in = 4'($urandom); rs_zero = 1'($urandom); flush = ($urandom_range(0, 15) == 0);
         #1;
         checks++; if (instr_ready !== m_ready()) begin failures++; $display("FAIL rnd_ready i=%0d got=%0b exp=%0b", i, instr_ready, m_ready()); end
         tick();
         checks++; if (ctrl_valid !== m_valid) begin failures++; $display("FAIL rnd_valid i=%0d got=%0b exp=%0b", i, ctrl_valid, m_valid); end
         checks++; if (md_busy !== (m_cnt != 0)) begin failures++; $display("FAIL rnd_busy i=%0d got=%0b exp=%0b", i, md_busy, m_cnt != 0); end
         if (m_valid) begin
            checks++; if (ctrl !== m_ctrl) begin failures++; $display("FAIL rnd_ctrl i=%0d instr=%h got=%h exp=%h", i, instr, ctrl, m_ctrl); end
         end
      end
      instr_valid = 0; flush = 0; flag_wr = 0; ctrl_ready = 1;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 80 && md_busy; i++) tick();
      checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL drain_timeout got=%0b exp=0", md_busy); end
      flag_wr = 1; flag_in = 4'b0100; instr = {MD_OPC, 21'h0_0823}; instr_valid = 1; #1;
      tick(); flag_wr = 0; instr_valid = 0;
      for (int i = 0; i < MD_LAT - 10 && i < MD_LAT - 1; i++) tick();
      checks++; if (md_busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%0b exp=1", md_busy); end
      reset = 0; tick(); reset = 1;
      checks++; if (md_busy !== 1'b0 || ctrl_valid !== 1'b0) begin failures++; $display("FAIL mid_reset busy=%0b valid=%0b exp=0", md_busy, ctrl_valid); end
      instr = {8'b01010100, 19'd5, 1'b0, 4'h0}; instr_valid = 1; #1;
      checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%0b exp=1", instr_ready); end
      tick(); instr_valid = 0;
      checks++; if (ctrl.br_taken !== 1'b0 || ctrl_valid !== 1'b1) begin failures++; $display("FAIL mid_flags got=%0b exp=0", ctrl.br_taken); end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_addi();
      test_mul_block();
      test_flag_bypass();
      test_back_to_back();
      test_flush();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
